// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_RST synchronous reset domains one at a time, gated by per-domain ack plus spacing.
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   req_i     reset request, accepted after MIN_WIDTH consecutive high cycles
//   sw_req_i  single-cycle software restart pulse
//   ack_i     per-domain ready acknowledge (level)
//   rst_o     sequenced resets, asserted level = RST_POL
//   busy_o    sequence in progress
//   done_o    all domains released and acknowledged
//   err_o     sticky ack-timeout flag
// Optional: define RSTSEQ_ACK_TIMEOUT_EN to enable the ack wait timeout (TIMEOUT_CYC).
module reset_sequencer #(
  parameter int   NUM_RST     = 4,
  parameter int   HOLD_CYC    = 8,
  parameter int   STEP_DLY    = 16,
  parameter int   MIN_WIDTH   = 4,
  parameter logic RST_POL     = 1'b0,
  parameter int   TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_i,
  input  logic               sw_req_i,
  input  logic [NUM_RST-1:0] ack_i,
  output logic [NUM_RST-1:0] rst_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);
  localparam int IW = NUM_RST > 1 ? $clog2(NUM_RST) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_RST - 1);
`ifdef RSTSEQ_ACK_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif
  typedef enum logic [1:0] {ASSERT, WAIT_ACK, STEP, DONE} state_t;
  state_t             r_state;
  logic [15:0]        r_cnt;
  logic [IW-1:0]      r_idx;
  logic [NUM_RST-1:0] r_rst;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [4:0]         r_req_cnt;
  logic               r_req_pulse;
  logic               w_restart;
  logic               w_to;
  logic               w_ack;
  assign w_restart = r_req_pulse | sw_req_i;
  // Timeout folds into the ack path so an expired wait behaves exactly like an ack.
  assign w_to  = TO_EN && !ack_i[r_idx] && (r_cnt == 16'(TIMEOUT_CYC - 1));
  assign w_ack = ack_i[r_idx] | w_to;
  assign rst_o  = r_rst;
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign err_o  = r_err;
  // Saturating filter: one pulse when the count first hits MIN_WIDTH, none again until req_i drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_cnt   <= '0;
      r_req_pulse <= 1'b0;
    end else begin
      r_req_cnt   <= !req_i ? 5'd0 : (r_req_cnt == 5'(MIN_WIDTH)) ? r_req_cnt : r_req_cnt + 5'd1;
      r_req_pulse <= req_i && (r_req_cnt == 5'(MIN_WIDTH - 1));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst   <= {NUM_RST{RST_POL}};
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_restart) begin
      r_state <= ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst   <= {NUM_RST{RST_POL}};
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ASSERT: begin
          if (r_cnt == 16'(HOLD_CYC - 1)) begin
            r_cnt    <= '0;
            r_rst[0] <= ~RST_POL;
            r_state  <= WAIT_ACK;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        WAIT_ACK: begin
          if (w_ack) begin
            r_cnt <= '0;
            r_err <= r_err | w_to;
            if (r_idx == LAST) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= STEP;
            end
          end else begin
            r_cnt <= r_cnt + 16'(TO_EN);
          end
        end
        STEP: begin
          if (r_cnt == 16'(STEP_DLY - 1)) begin
            r_cnt                <= '0;
            r_rst[r_idx + 1'b1]  <= ~RST_POL;
            r_idx                <= r_idx + 1'b1;
            r_state              <= WAIT_ACK;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized and directed checks of reset_sequencer against an event-scheduling model.
module tb_reset_sequencer;
  localparam int N = 4, HOLD = 8, STEP = 16, MINW = 4, TO = 16;
  localparam logic POL = 1'b0;
  logic clk = 0, rst_n = 1, req_i = 0, sw_req_i = 0;
  logic [N-1:0] ack_i = '1;
  logic [N-1:0] rst_o;
  logic busy_o, done_o, err_o;
  int errs = 0, checks = 0;
  int n, rel, due, wst, hcnt, done_edge;
  bit pend, m_done, m_err;
  int rec[N];

  reset_sequencer #(.NUM_RST(N), .HOLD_CYC(HOLD), .STEP_DLY(STEP), .MIN_WIDTH(MINW),
                    .RST_POL(POL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .sw_req_i(sw_req_i), .ack_i(ack_i),
    .rst_o(rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [N-1:0] exp_rst();
    logic [N-1:0] m;
    m = N'((1 << rel) - 1);
    return POL ? ~m : m;
  endfunction

  // Model: the next release is scheduled as an absolute edge number; acks reschedule it.
  task automatic model_step();
    bit rs, a;
    n++;
    rs = sw_req_i || pend;
    pend = req_i && (hcnt == MINW - 1);
    hcnt = !req_i ? 0 : (hcnt < MINW ? hcnt + 1 : hcnt);
    if (rs) begin
      rel = 0; due = n + HOLD; m_done = 0;
    end else if (due == n) begin
      rel++; due = -1; wst = n;
    end else if (due < 0 && !m_done) begin
      a = ack_i[rel-1];
`ifdef RSTSEQ_ACK_TIMEOUT_EN
      if (!a && n - wst == TO) begin a = 1; m_err = 1; end
`endif
      if (a) begin
        if (rel == N) m_done = 1;
        else due = n + STEP;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    for (int b = 0; b < N; b++) if (rst_o[b] != POL && rec[b] < 0) rec[b] = n;
    if (done_o && done_edge < 0) done_edge = n;
    chk("rst_o", 32'(rst_o), 32'(exp_rst()));
    chk("busy_o", 32'(busy_o), 32'(!m_done));
    chk("done_o", 32'(done_o), 32'(m_done));
    chk("err_o", 32'(err_o), 32'(m_err));
  endtask

  task automatic do_reset();
    #2;
    rst_n = 0;
    n = 0; rel = 0; due = HOLD; wst = 0; hcnt = 0; pend = 0; m_done = 0; m_err = 0;
    done_edge = -1;
    for (int b = 0; b < N; b++) rec[b] = -1;
    #1;
    chk("rst_async", 32'(rst_o), 32'({N{POL}}));
    chk("rst_busy", 32'(busy_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic restart_check(input string tag);
    chk({tag, "_asserted"}, 32'(rst_o), 32'({N{POL}}));
    repeat (HOLD - 1) tick();
    chk({tag, "_hold"}, 32'(rst_o), 32'({N{POL}}));
    tick();
    chk({tag, "_rel0"}, 32'(rst_o[0]), 32'(!POL));
  endtask

  initial begin
    // Basic sequence, constant ack
    do_reset();
    repeat (70) tick();
    chk("t1_rel0", rec[0], 8);
    chk("t1_rel1", rec[1], 25);
    chk("t1_rel2", rec[2], 42);
    chk("t1_rel3", rec[3], 59);
    chk("t1_done", done_edge, 60);
    // Short request glitch is ignored, full-width request restarts
    req_i = 1; repeat (3) tick(); req_i = 0; repeat (5) tick();
    chk("t3_glitch", 32'(done_o), 32'd1);
    req_i = 1; repeat (4) tick(); req_i = 0; tick();
    restart_check("t3");
    repeat (22) tick();
    // Software restart while stepping between stages 1 and 2
    sw_req_i = 1; tick(); sw_req_i = 0;
    restart_check("t4");
    repeat (60) tick();
    // Filtered request and software pulse landing together give one restart
    req_i = 1; repeat (4) tick(); req_i = 0; sw_req_i = 1; tick(); sw_req_i = 0;
    restart_check("t4_both");
    repeat (60) tick();
    // Late ack on stage 1
    do_reset();
    ack_i = 4'b1101;
    while (n < 99) tick();
    ack_i = '1;
    repeat (40) tick();
    chk("t2_rel2", rec[2], 116);
    chk("t2_done", done_edge, 134);
    // Asynchronous reset mid-sequence, then a clean replay
    do_reset();
    while (n < 45) tick();
    chk("t5_stage2", 32'(rst_o), 32'(POL ? 4'b1000 : 4'b0111));
    do_reset();
    repeat (62) tick();
    chk("t5_rel0", rec[0], 8);
    chk("t5_rel3", rec[3], 59);
    // Stage 0 ack stuck low
    do_reset();
    ack_i = 4'b1110;
    repeat (60) tick();
`ifdef RSTSEQ_ACK_TIMEOUT_EN
    chk("t6_rel1", rec[1], 40);
    chk("t6_err", 32'(err_o), 32'd1);
`else
    chk("t6_stuck", 32'(rst_o[1]), 32'(POL));
    chk("t6_err", 32'(err_o), 32'd0);
`endif
    sw_req_i = 1; tick(); sw_req_i = 0;
    repeat (20) tick();
    ack_i = '1;
    // Random ack, request and software pulse traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ack_i = N'($urandom);
      sw_req_i = ($urandom_range(0, 99) == 0);
      req_i = ($urandom_range(0, 9) < (req_i ? 8 : 1));
      tick();
    end
    req_i = 0; sw_req_i = 0; ack_i = '1;
    repeat (80) tick();
    chk("final_done", 32'(done_o), 32'd1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
